// File: rtl/fp_alu_arbiter.sv
// fp_alu_arbiter: round-robin sharing of one FP unit set among requesters, one op in flight, watchdog error on a silent unit
module fp_alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [3*NUM_REQ-1:0] req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_b,
  output logic [NUM_REQ-1:0] req_accept,
  output logic [NUM_REQ-1:0] resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic resp_error,
  output logic busy,
  output logic mult_start,
  output logic add_start,
  output logic divide_start,
  output logic exponent_start,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b,
  input  logic [DATA_WIDTH-1:0] mult_result,
  input  logic [DATA_WIDTH-1:0] add_result,
  input  logic [DATA_WIDTH-1:0] divide_result,
  input  logic [DATA_WIDTH-1:0] exponent_result,
  input  logic mult_data_ready,
  input  logic add_data_ready,
  input  logic divide_data_ready,
  input  logic exponent_data_ready
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  state_t state, state_n;
  logic [GW-1:0] grant, last_grant, pick;
  logic [2:0] op;
  logic [DATA_WIDTH-1:0] cap_a, cap_b, unit_result;
  logic [CW-1:0] count;
  logic err, unit_ready, legal, timed_out, issue;
  logic [2:0] op_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign op_arr[i] = req_op[3*i +: 3];
    assign a_arr[i] = req_operand_a[DATA_WIDTH*i +: DATA_WIDTH];
    assign b_arr[i] = req_operand_b[DATA_WIDTH*i +: DATA_WIDTH];
  end

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] last, input int k);
    int s;
    s = int'(last) + k;
    return GW'(s >= NUM_REQ ? s - NUM_REQ : s);
  endfunction

  // Walk offsets from farthest to nearest so the nearest set bit after last_grant wins
  always_comb begin
    pick = last_grant;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[rr_idx(last_grant, k)]) pick = rr_idx(last_grant, k);
  end

  assign legal = op <= 3'd4;
  assign unit_ready = op == 3'd0 ? exponent_data_ready : op == 3'd1 ? mult_data_ready :
                      op == 3'd2 ? divide_data_ready : add_data_ready;
  assign unit_result = op == 3'd0 ? exponent_result : op == 3'd1 ? mult_result :
                       op == 3'd2 ? divide_result : add_result;
  assign timed_out = count == CW'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |req_valid ? ISSUE : IDLE;
      ISSUE:   state_n = legal ? WAIT : RESPOND;
      WAIT:    state_n = unit_ready || timed_out ? RESPOND : WAIT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      op <= '0;
      cap_a <= '0;
      cap_b <= '0;
      count <= '0;
      err <= 1'b0;
      resp_data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req_valid) begin
        grant <= pick;
        op <= op_arr[pick];
        cap_a <= a_arr[pick];
        cap_b <= b_arr[pick];
      end
      if (state == ISSUE) begin
        count <= '0;
        if (!legal) begin
          err <= 1'b1;
          resp_data <= '0;
        end
      end
      if (state == WAIT) begin
        count <= count + 1'b1;
        if (unit_ready) begin
          err <= 1'b0;
          resp_data <= unit_result;
        end else if (timed_out) begin
          err <= 1'b1;
          resp_data <= '0;
        end
      end
      if (state == RESPOND) last_grant <= grant;
    end
  end

  assign issue = state == ISSUE;
  assign busy = state != IDLE;
  assign req_accept = issue ? NUM_REQ'(1) << grant : '0;
  assign resp_valid = state == RESPOND ? NUM_REQ'(1) << grant : '0;
  assign resp_error = state == RESPOND && err;
  assign exponent_start = issue && op == 3'd0;
  assign mult_start = issue && op == 3'd1;
  assign divide_start = issue && op == 3'd2;
  assign add_start = issue && (op == 3'd3 || op == 3'd4);
  assign operand_a = cap_a;
  // Subtraction reuses the adder with operand_b negated
  assign operand_b = op == 3'd4 ? {~cap_b[DATA_WIDTH-1], cap_b[DATA_WIDTH-2:0]} : cap_b;
endmodule

// File: tb/tb_fp_alu_arbiter.sv
// tb_fp_alu_arbiter: directed stimulus checked every cycle against a transaction-level model of the arbiter
module tb_fp_alu_arbiter;
  localparam int N = 3, W = 32, TO = 16;
  localparam int EXP = 0, MUL = 1, DIV = 2, ADD = 3, SUB = 4;
  logic clock = 1'b0, reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [3*N-1:0] req_op = '0;
  logic [W*N-1:0] req_operand_a = '0, req_operand_b = '0;
  logic [N-1:0] req_accept, resp_valid;
  logic [W-1:0] resp_data, operand_a, operand_b;
  logic resp_error, busy, mult_start, add_start, divide_start, exponent_start;
  logic [W-1:0] mult_result = '0, add_result = '0, divide_result = '0, exponent_result = '0;
  logic mult_data_ready = 1'b0, add_data_ready = 1'b0, divide_data_ready = 1'b0, exponent_data_ready = 1'b0;
  int checks = 0, errors = 0;

  bit m_active = 1'b0, m_err = 1'b0, m_rdy;
  int m_g = 0, m_last = N - 1, m_age = 0, m_resp_at = 0;
  logic [2:0] m_op = '0;
  logic [W-1:0] m_opa = '0, m_opb = '0, m_data = '0, m_res;

  fp_alu_arbiter #(.DATA_WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_operand_a(req_operand_a), .req_operand_b(req_operand_b),
    .req_accept(req_accept), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_error(resp_error), .busy(busy), .mult_start(mult_start), .add_start(add_start),
    .divide_start(divide_start), .exponent_start(exponent_start),
    .operand_a(operand_a), .operand_b(operand_b),
    .mult_result(mult_result), .add_result(add_result), .divide_result(divide_result),
    .exponent_result(exponent_result), .mult_data_ready(mult_data_ready),
    .add_data_ready(add_data_ready), .divide_data_ready(divide_data_ready),
    .exponent_data_ready(exponent_data_ready)
  );

  always #5 clock = ~clock;

  // Model: cycle 1 after a grant is the issue cycle; the response cycle is fixed once known
  always @(posedge clock or posedge reset) begin
    m_rdy = (m_op == 3'd0 && exponent_data_ready) || (m_op == 3'd1 && mult_data_ready) ||
            (m_op == 3'd2 && divide_data_ready) || ((m_op == 3'd3 || m_op == 3'd4) && add_data_ready);
    m_res = m_op == 3'd0 ? exponent_result : m_op == 3'd1 ? mult_result :
            m_op == 3'd2 ? divide_result : add_result;
    if (reset) begin
      m_active = 1'b0; m_last = N - 1; m_data = '0; m_err = 1'b0;
      m_opa = '0; m_opb = '0; m_op = '0; m_age = 0; m_resp_at = 0;
    end else if (!m_active) begin
      if (req_valid != '0) begin
        for (int k = N; k >= 1; k--) if (req_valid[(m_last + k) % N]) m_g = (m_last + k) % N;
        m_op = req_op[3*m_g +: 3];
        m_opa = req_operand_a[W*m_g +: W];
        m_opb = req_operand_b[W*m_g +: W] ^ (m_op == 3'd4 ? 32'h8000_0000 : 32'h0);
        m_active = 1'b1; m_age = 1; m_resp_at = 0;
      end
    end else if (m_age == m_resp_at) begin
      m_active = 1'b0; m_last = m_g;
    end else begin
      if (m_age == 1 && m_op > 3'd4) begin m_resp_at = 2; m_data = '0; m_err = 1'b1; end
      else if (m_age >= 2 && m_rdy) begin m_resp_at = m_age + 1; m_data = m_res; m_err = 1'b0; end
      else if (m_age == TO + 1) begin m_resp_at = TO + 2; m_data = '0; m_err = 1'b1; end
      m_age++;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [N-1:0] oh;
    bit iss, rsp;
    oh = m_active ? N'(1) << m_g : '0;
    iss = m_active && m_age == 1;
    rsp = m_active && m_age == m_resp_at;
    chk("busy", busy, m_active);
    chk("req_accept", req_accept, iss ? oh : '0);
    chk("resp_valid", resp_valid, rsp ? oh : '0);
    chk("resp_error", resp_error, rsp && m_err);
    chk("resp_data", resp_data, m_data);
    chk("exponent_start", exponent_start, iss && m_op == 3'd0);
    chk("mult_start", mult_start, iss && m_op == 3'd1);
    chk("divide_start", divide_start, iss && m_op == 3'd2);
    chk("add_start", add_start, iss && (m_op == 3'd3 || m_op == 3'd4));
    chk("operand_a", operand_a, m_opa);
    chk("operand_b", operand_b, m_opb);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    if (!reset) compare();
  endtask

  task automatic issue(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i] = 1'b1;
    req_op[3*i +: 3] = op;
    req_operand_a[W*i +: W] = a;
    req_operand_b[W*i +: W] = b;
  endtask

  task automatic pulse(input int u, input logic [W-1:0] v);
    case (u)
      EXP: begin exponent_result = v; exponent_data_ready = 1'b1; end
      MUL: begin mult_result = v; mult_data_ready = 1'b1; end
      DIV: begin divide_result = v; divide_data_ready = 1'b1; end
      default: begin add_result = v; add_data_ready = 1'b1; end
    endcase
    tick();
    {exponent_data_ready, mult_data_ready, divide_data_ready, add_data_ready} = '0;
  endtask

  task automatic await_accept(input logic [N-1:0] exp);
    int n = 0;
    while (req_accept == '0 && n < 20) begin tick(); n++; end
    chk("grant", req_accept, exp);
    req_valid = req_valid & ~req_accept;
  endtask

  task automatic await_resp(input logic [N-1:0] exp, input logic [W-1:0] data, input logic err, input int lat);
    int n = 0;
    while (resp_valid == '0 && n < 40) begin tick(); n++; end
    chk("resp_valid_lit", resp_valid, exp);
    chk("resp_data_lit", resp_data, data);
    chk("resp_error_lit", resp_error, err);
    if (lat >= 0) chk("resp_latency", n, lat);
  endtask

  task automatic serve(input int u, input logic [W-1:0] v, input logic [N-1:0] exp);
    tick();
    pulse(u, v);
    await_resp(exp, v, 1'b0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset busy", busy, 0);
    chk("reset req_accept", req_accept, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset operand_b", operand_b, 0);
    reset = 1'b0;
    tick();
    // All three at once: order 0,1,2; a stray divide ready during the mult is dropped
    issue(0, MUL, 32'h4000_0000, 32'h4080_0000);
    issue(1, DIV, 32'h3F80_0000, 32'h4000_0000);
    issue(2, EXP, 32'h3F80_0000, 32'h0);
    await_accept(3'b001);
    tick();
    pulse(DIV, 32'hDEAD_BEEF);
    pulse(MUL, 32'h4100_0000);
    await_resp(3'b001, 32'h4100_0000, 1'b0, 0);
    await_accept(3'b010);
    serve(DIV, 32'h3F00_0000, 3'b010);
    await_accept(3'b100);
    serve(EXP, 32'h402D_F854, 3'b100);
    issue(0, ADD, 32'h3F80_0000, 32'h3F80_0000);
    issue(2, MUL, 32'h4040_0000, 32'h4040_0000);
    await_accept(3'b001);
    serve(ADD, 32'h4000_0000, 3'b001);
    await_accept(3'b100);
    serve(MUL, 32'h4110_0000, 3'b100);
    // Mult on requester 1 with a slow unit
    issue(1, MUL, 32'h4000_0000, 32'h4040_0000);
    await_accept(3'b010);
    chk("mult_start issue", mult_start, 1);
    chk("operand_a mult", operand_a, 32'h4000_0000);
    tick();
    chk("mult_start one cycle", mult_start, 0);
    repeat (3) tick();
    pulse(MUL, 32'h40C0_0000);
    await_resp(3'b010, 32'h40C0_0000, 1'b0, 0);
    // Subtract: adder with negated operand_b
    issue(0, SUB, 32'h4000_0000, 32'h3F80_0000);
    await_accept(3'b001);
    chk("add_start sub", add_start, 1);
    chk("operand_b negated", operand_b, 32'hBF80_0000);
    serve(ADD, 32'h3F80_0000, 3'b001);
    // Watchdog, then a normal request
    issue(1, DIV, 32'h4000_0000, 32'h0);
    await_accept(3'b010);
    await_resp(3'b010, 32'h0, 1'b1, TO + 1);
    issue(2, MUL, 32'h4000_0000, 32'h4000_0000);
    await_accept(3'b100);
    serve(MUL, 32'h4080_0000, 3'b100);
    // Illegal op
    issue(2, 3'b110, 32'h1, 32'h2);
    await_accept(3'b100);
    chk("no start illegal", {mult_start, add_start, divide_start, exponent_start}, 0);
    await_resp(3'b100, 32'h0, 1'b1, 1);
    issue(0, ADD, 32'h3F80_0000, 32'h4000_0000);
    await_accept(3'b001);
    serve(ADD, 32'h4040_0000, 3'b001);
    // Reset while waiting on the unit
    issue(1, MUL, 32'h4000_0000, 32'h4000_0000);
    await_accept(3'b010);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("async busy", busy, 0);
    chk("async operand_a", operand_a, 0);
    chk("async operand_b", operand_b, 0);
    chk("async resp_data", resp_data, 0);
    chk("async pulses", {req_accept, resp_valid, resp_error, mult_start, add_start, divide_start, exponent_start}, 0);
    @(negedge clock);
    reset = 1'b0;
    pulse(MUL, 32'h1234_5678);
    repeat (2) begin
      chk("no resp after reset", resp_valid, 0);
      tick();
    end
    issue(0, MUL, 32'h4000_0000, 32'h4000_0000);
    issue(1, ADD, 32'h4000_0000, 32'h4000_0000);
    await_accept(3'b001);
    serve(MUL, 32'h4080_0000, 3'b001);
    await_accept(3'b010);
    serve(ADD, 32'h4080_0000, 3'b010);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/fp_alu_arbiter.md
# fp_alu_arbiter

Shares one set of floating-point units (mult, add, divide, exponent) among NUM_REQ requesters, typically one term_accumulator per expression index. The arbiter grants requesters round-robin, keeps one operation in flight, drives the unit start pulses and operands, and returns each result to its requester. It also covers a unit that never answers: a watchdog ends the operation with an error response.

## Interface
- DATA_WIDTH, 32, operand/result width (IEEE-754 single)
- NUM_REQ, 3, number of requesters (2..8)
- TIMEOUT_CYCLES, 256, maximum cycles spent waiting on a unit before an error response
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- req_valid  in  NUM_REQ  per-requester request; held until req_accept
- req_op  in  3*NUM_REQ  op code per requester: 000 exp, 001 mult, 010 div, 011 add, 100 sub, others illegal
- req_operand_a / req_operand_b  in  DATA_WIDTH*NUM_REQ  packed operands, slot i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_accept  out  NUM_REQ  one-cycle pulse: request captured
- resp_valid  out  NUM_REQ  one-cycle pulse to granted requester
- resp_data  out  DATA_WIDTH  result, valid with resp_valid, held until next response
- resp_error  out  1  high with resp_valid on timeout or illegal op
- busy  out  1  high in any state other than IDLE
- mult_start, add_start, divide_start, exponent_start  out  1 each  unit start pulses
- operand_a, operand_b  out  DATA_WIDTH  unit operands
- mult_result, add_result, divide_result, exponent_result  in  DATA_WIDTH  unit results
- mult_data_ready, add_data_ready, divide_data_ready, exponent_data_ready  in  1 each  unit done pulses

## Operation
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE, any req_valid high:
  - Select grant g by round-robin: search starts at (last_grant+1) mod NUM_REQ and takes the first set bit.
  - Register g, req_op[g] and both operands.
  - Go to ISSUE.
  - req_valid is sampled only in IDLE.
- ISSUE:
  - req_accept[g]=1.
  - Drive operand_a = captured a and operand_b = captured b.
  - For op 100, flip only the sign bit of operand_b (operand_b[DATA_WIDTH-1] inverted) and assert add_start.
  - Ops 000/001/010/011 assert exponent_start/mult_start/divide_start/add_start respectively.
  - Legal op: go to WAIT, clear the watchdog counter.
  - Illegal op (101..111): no start pulse, set error flag, resp_data<=0, go to RESPOND.
- WAIT:
  - Only the ready of the selected unit (add for 011/100) is honoured; readies from other units are ignored.
  - On ready: resp_data<=that unit's result, error flag<=0, go to RESPOND.
  - Otherwise increment the counter. When the count reaches TIMEOUT_CYCLES: error flag<=1, resp_data<=0, go to RESPOND.
  - Ready in the same cycle as timeout: ready wins.
- RESPOND: resp_valid[g]=1, resp_error=error flag, last_grant<=g, go to IDLE.
- operand_a/operand_b hold their values from ISSUE through RESPOND; they are 0 only after reset.
- Unit readies arriving in IDLE, ISSUE or RESPOND are ignored and dropped.
- Requester contract: hold req_valid and operands until req_accept, drop req_valid no later than the cycle after req_accept. A requester that holds req_valid issues a new request.

## Timing
- Reset values: state IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), all outputs 0.
- Reset mid-operation: the in-flight operation is abandoned with no resp_valid; a later unit ready is ignored.
- Start pulses and req_accept are high for exactly one cycle, the ISSUE cycle.
- Cycle numbering: request seen at edge 0, ISSUE in cycle 1, WAIT from cycle 2.
  - A unit ready sampled in cycle k gives resp_valid in cycle k+1 and IDLE in cycle k+2.
  - Minimum request-to-response is 3 cycles (unit ready in cycle 2).
  - Illegal op: resp_valid in cycle 2.
- Back-to-back requests: the next grant is taken at the IDLE edge following RESPOND, so one IDLE cycle is the minimum gap.
- Timeout response comes exactly TIMEOUT_CYCLES+1 cycles after ISSUE.

## Test plan
- Req 1 mult, a=0x40000000, b=0x40400000, mult_data_ready 4 cycles after mult_start with 0x40C00000 -> req_accept[1] and mult_start each high one cycle; resp_valid[1] the cycle after ready; resp_data=0x40C00000; resp_error=0.
- Req 0 sub, a=0x40000000, b=0x3F800000 -> add_start pulse; operand_b=0xBF800000; add result 0x3F800000 returned on resp_valid[0].
- All three requests asserted together after reset -> grant order 0,1,2. Then requests 0 and 2 together (last_grant=2) -> 0 is served before 2. A stray divide_data_ready during a mult is ignored.
- TIMEOUT_CYCLES=16, no unit ready -> resp_valid and resp_error high, resp_data=0, 17 cycles after ISSUE. A following legal request completes normally.
- Req 2 op 110 -> no start pulse; resp_valid[2] and resp_error high in cycle 2; resp_data=0.
- reset pulsed in WAIT -> outputs 0 immediately (no clock edge required). A mult_data_ready arriving afterwards produces no resp_valid. The next request is granted to requester 0 first.
